serial_frame_tx: RTL and testbench
==================================

// Module: serial_frame_tx
// PURPOSE
//  Parallel-to-serial frame transmitter. Accepts one data word per valid/ready handshake and shifts it out LSB-first on a
//  single wire: start bit (0), DATA_W data bits, optional even-parity bit, stop bit (1). Transmit end of the team's serial
//  link; the line idles high. Single clock domain; bit timing derived from a clock-divide counter.
// PARAMETERS
//  DATA_W        8   data bits per frame (1..16)
//  CLKS_PER_BIT  4   clock cycles each serial bit is held on txd (>=1)
//  PARITY_EN     1   1: even-parity bit after data bits; 0: no parity bit
// PORTS
//  clk       in   1       system clock, rising-edge
//  reset     in   1       asynchronous, active-high reset
//  tx_data   in   DATA_W  word to send; sampled only on accept
//  tx_valid  in   1       tx_data valid
//  tx_ready  out  1       block can accept a word this cycle
//  txd       out  1       serial line output, idle high
//  busy      out  1       frame in progress (any state except IDLE)
//  done      out  1       one-cycle pulse in the last cycle of the stop bit
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, txd=1, tx_ready=1, busy=0, done=0, shift reg/counters=0. Reset mid-frame
//   aborts the frame at once; the line returns high with no partial stop bit.
//  Accept: tx_valid & tx_ready at a rising edge -> tx_data latched into shift reg, parity = ^tx_data latched, state->START.
//   tx_ready = (state==IDLE), registered. No accept while busy; a valid held during busy is taken after return to IDLE.
//  States (each bit held exactly CLKS_PER_BIT cycles, counted by bit_cnt 0..CLKS_PER_BIT-1):
//   IDLE   txd=1; on accept -> START.
//   START  txd=0; at end of bit -> DATA, idx=0.
//   DATA   txd=shift[0]; at end of bit shift right, idx++; after bit DATA_W-1 -> PARITY if PARITY_EN else STOP.
//   PARITY txd=latched even parity (total ones in data+parity is even); at end of bit -> STOP.
//   STOP   txd=1; done=1 in its final cycle; at end of bit -> IDLE.
//  txd registered: changes one cycle after the edge that enters a state (first START cycle is the cycle after accept).
//  Frame length = (2 + DATA_W + PARITY_EN) * CLKS_PER_BIT cycles; tx_ready re-asserts the cycle after done.
//  Back-to-back: tx_valid held high -> next accept on the first IDLE cycle, so frames are separated by exactly one
//   idle-high cycle.
//  CLKS_PER_BIT=1: every state lasts one cycle; the counter never exceeds 0.
//  tx_data changes after accept have no effect on the frame in flight.
//  No X on outputs after reset; idx/bit_cnt wrap only via explicit reload to 0.
// TESTING
//  1 reset high 3 cycles, then low, no valid -> txd=1, tx_ready=1, busy=0, done=0 throughout.
//  2 defaults, send 8'hA5 -> txd per 4 cycles: 0,1,0,1,0,0,1,0,1,0(parity),1; done high in cycle 44 after accept only.
//  3 PARITY_EN=0, CLKS_PER_BIT=1, send 8'h01 -> txd 0,1,0,0,0,0,0,0,0,1 on consecutive cycles; frame = 10 cycles.
//  4 tx_valid held with 8'hFF then 8'h00 -> second start bit begins exactly one idle cycle after first done; parity 0 both.
//  5 assert reset during data bit 3 of 8'h3C -> txd=1, busy=0 immediately (async); next send 8'h3C is a complete frame.
//  6 change tx_data every cycle during a frame of 8'h81 -> serialized bits still match 8'h81; tx_ready=0 whole frame.

Source files
------------

// File: rtl/serial_frame_tx.sv
// Parallel-to-serial frame transmitter: start bit, LSB-first data, optional even parity, stop bit.
// The line idles high and every bit is held for CLKS_PER_BIT clock cycles.
module serial_frame_tx #(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned PARITY_EN    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              txd,
    output logic              busy,
    output logic              done
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IDX_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t             state_q,    state_d;
    logic [CNT_W-1:0]   bit_cnt_q,  bit_cnt_d;
    logic [IDX_W-1:0]   idx_q,      idx_d;
    logic [DATA_W-1:0]  shift_q,    shift_d;
    logic               parity_q,   parity_d;
    logic               txd_q,      txd_d;
    logic               done_q,     done_d;
    logic               ready_q,    ready_d;
    logic               bit_end;

    assign bit_end = (bit_cnt_q == BIT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            txd_q     <= 1'b1;
            done_q    <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            txd_q     <= txd_d;
            done_q    <= done_d;
            ready_q   <= ready_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        parity_d  = parity_q;

        if (state_q == S_IDLE) begin
            if (tx_valid && ready_q) begin
                shift_d   = tx_data;
                parity_d  = ^tx_data;
                bit_cnt_d = '0;
                idx_d     = '0;
                state_d   = S_START;
            end
        end else if (!bit_end) begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end else begin
            bit_cnt_d = '0;
            case (state_q)
                S_START: begin
                    state_d = S_DATA;
                    idx_d   = '0;
                end
                S_DATA: begin
                    shift_d = shift_q >> 1;
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
                S_PARITY: state_d = S_STOP;
                default:  state_d = S_IDLE;
            endcase
        end

        // Outputs are registered from the next state so txd tracks the state it is entering.
        case (state_d)
            S_START:  txd_d = 1'b0;
            S_DATA:   txd_d = shift_d[0];
            S_PARITY: txd_d = parity_d;
            default:  txd_d = 1'b1;
        endcase
        done_d  = (state_d == S_STOP) && (bit_cnt_d == BIT_LAST);
        ready_d = (state_d == S_IDLE);
    end

    assign txd      = txd_q;
    assign done     = done_q;
    assign tx_ready = ready_q;
    assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx: a default instance (8N+parity, 4 clocks/bit) and a
// fast instance (no parity, 1 clock/bit); expected line bits are queued and popped per bit.
module tb_serial_frame_tx;

    logic       clk;
    logic       rst;
    logic [7:0] data_a, data_b;
    logic       valid_a, valid_b;
    logic       ready_a, ready_b;
    logic       txd_a, txd_b;
    logic       busy_a, busy_b;
    logic       done_a, done_b;

    int checks   = 0;
    int failures = 0;
    bit exp_q[$];

    serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) dut_a (
        .clk(clk), .reset(rst), .tx_data(data_a), .tx_valid(valid_a),
        .tx_ready(ready_a), .txd(txd_a), .busy(busy_a), .done(done_a)
    );

    serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_EN(0)) dut_b (
        .clk(clk), .reset(rst), .tx_data(data_b), .tx_valid(valid_b),
        .tx_ready(ready_b), .txd(txd_b), .busy(busy_b), .done(done_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic [7:0] d, input bit par_en);
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
        if (par_en) exp_q.push_back(^d);
        exp_q.push_back(1'b1);
    endtask

    function automatic logic pop_exp();
        if (exp_q.size() == 0) return 1'bx;
        return exp_q.pop_front();
    endfunction

    task automatic idle_checks(input string tag);
        check({tag, ".txd_a"},   txd_a,   1'b1);
        check({tag, ".ready_a"}, ready_a, 1'b1);
        check({tag, ".busy_a"},  busy_a,  1'b0);
        check({tag, ".done_a"},  done_a,  1'b0);
    endtask

    // Called at a negedge with dut_a idle; returns at the negedge of the first idle cycle after done.
    task automatic frame_a(input string tag, input logic [7:0] d, input bit keep,
                           input logic [7:0] nd, input bit scramble);
        logic e;
        e = 1'b1;
        check({tag, ".ready_pre"}, ready_a, 1'b1);
        data_a  = d;
        valid_a = 1'b1;
        push_frame(d, 1'b1);
        for (int c = 1; c <= 44; c++) begin
            @(negedge clk);
            if (c == 1) begin
                valid_a = keep;
                if (keep) data_a = nd;
            end
            if (scramble) data_a = 8'($urandom);
            if ((c - 1) % 4 == 0) e = pop_exp();
            check($sformatf("%s.txd[c%0d]", tag, c), txd_a, e);
            check($sformatf("%s.done[c%0d]", tag, c), done_a, logic'(c == 44));
            check($sformatf("%s.busy[c%0d]", tag, c), busy_a, 1'b1);
            check($sformatf("%s.ready[c%0d]", tag, c), ready_a, 1'b0);
        end
        @(negedge clk);
        check({tag, ".idle_txd"},   txd_a,   1'b1);
        check({tag, ".idle_ready"}, ready_a, 1'b1);
        check({tag, ".idle_busy"},  busy_a,  1'b0);
        check({tag, ".idle_done"},  done_a,  1'b0);
        if (!keep) data_a = 8'h00;
    endtask

    task automatic frame_b(input string tag, input logic [7:0] d);
        check({tag, ".ready_pre"}, ready_b, 1'b1);
        data_b  = d;
        valid_b = 1'b1;
        push_frame(d, 1'b0);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) valid_b = 1'b0;
            check($sformatf("%s.txd[c%0d]", tag, c), txd_b, pop_exp());
            check($sformatf("%s.done[c%0d]", tag, c), done_b, logic'(c == 10));
            check($sformatf("%s.busy[c%0d]", tag, c), busy_b, 1'b1);
        end
        @(negedge clk);
        check({tag, ".idle_txd"},   txd_b,   1'b1);
        check({tag, ".idle_ready"}, ready_b, 1'b1);
        check({tag, ".idle_busy"},  busy_b,  1'b0);
    endtask

    initial begin
        rst     = 1'b1;
        data_a  = 8'h00;
        data_b  = 8'h00;
        valid_a = 1'b0;
        valid_b = 1'b0;

        // Reset held, then released with no traffic
        repeat (3) @(negedge clk);
        idle_checks("reset_held");
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            idle_checks($sformatf("reset_idle%0d", i));
            check("reset_idle.txd_b",   txd_b,   1'b1);
            check("reset_idle.ready_b", ready_b, 1'b1);
            check("reset_idle.busy_b",  busy_b,  1'b0);
            check("reset_idle.done_b",  done_b,  1'b0);
        end

        // Default frame
        frame_a("a5", 8'hA5, 1'b0, 8'h00, 1'b0);
        @(negedge clk);

        // Single-cycle bits, no parity
        frame_b("b01", 8'h01);
        frame_b("b5a", 8'h5A);

        // Back-to-back with valid held: one idle cycle between frames
        frame_a("ff", 8'hFF, 1'b1, 8'h00, 1'b0);
        frame_a("00", 8'h00, 1'b0, 8'h00, 1'b0);
        @(negedge clk);

        // Async reset during data bit 3 of 8'h3C
        data_a  = 8'h3C;
        valid_a = 1'b1;
        @(negedge clk);
        valid_a = 1'b0;
        repeat (17) @(negedge clk);
        check("rst_mid.busy_before", busy_a, 1'b1);
        check("rst_mid.txd_bit3",    txd_a,  1'b1);
        #1 rst = 1'b1;
        #1;
        idle_checks("rst_mid_async");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        idle_checks("rst_mid_after");
        frame_a("3c", 8'h3C, 1'b0, 8'h00, 1'b0);

        // Input data churning while a frame is in flight
        frame_a("81scr", 8'h81, 1'b0, 8'h00, 1'b1);

        check("queue_drained", logic'(exp_q.size() == 0), 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
